// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register-file memory.
// Every access phase lasts WAIT_CYCLES+1 cycles; bad addresses complete with o_pslverr.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rst_apb,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr
);

  localparam int                  IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_pwrite;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic             w_setup;
  logic             w_xfer;
  logic             w_done;
  logic             w_commit;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;

  assign w_setup  = i_psel & ~i_penable;
  assign w_xfer   = i_psel & i_penable;
  assign w_idx    = i_paddr[IDX_W+1:2];
  assign w_err    = (i_paddr[1:0] != 2'b00) | (i_paddr >= MEM_BYTES);

  // Completion is decoded from state only, so o_pready has no path from the bus inputs.
  assign w_done   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_commit = w_done & w_xfer & r_pwrite & ~r_err;

  assign o_pready  = w_done;
  assign o_pslverr = w_done & r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
    if (i_rst_apb) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_pwrite <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_pwdata <= '0;
      o_prdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_pwrite <= i_pwrite;
            r_err    <= w_err;
            r_idx    <= w_idx;
            r_pwdata <= i_pwdata;
            r_cnt    <= 4'(WAIT_CYCLES);
            r_state  <= S_ACCESS;
            if (!i_pwrite) o_prdata <= w_err ? '0 : r_mem[w_idx];
          end
        end
        S_ACCESS: begin
          // A dropped psel/penable aborts the transfer; it is never a new setup.
          if (!w_xfer)              r_state <= S_IDLE;
          else if (r_cnt != 4'd0)   r_cnt   <= r_cnt - 4'd1;
          else                      r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the memory is cleared by reset, so it must stay in flops rather than map to a RAM macro.
  always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
    if (i_rst_apb) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_idx] <= r_pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: two instances (2 and 0 wait states) checked
// every cycle against a transfer-level model, plus literal expectations.
module tb_apb_slave_mem;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] mem_m       [2][16];
  logic [31:0] exp_prdata  [2];
  logic        exp_pready  [2];
  logic        exp_pslverr [2];
  bit          started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .WAIT_CYCLES(W0)) u_dut0 (
    .i_clk_apb (clk),        .i_rst_apb (rst),
    .i_psel    (psel[0]),    .i_penable (penable[0]),
    .i_pwrite  (pwrite[0]),  .i_paddr   (paddr[0]),
    .i_pwdata  (pwdata[0]),  .o_prdata  (prdata[0]),
    .o_pready  (pready[0]),  .o_pslverr (pslverr[0])
  );

  apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .WAIT_CYCLES(W1)) u_dut1 (
    .i_clk_apb (clk),        .i_rst_apb (rst),
    .i_psel    (psel[1]),    .i_penable (penable[1]),
    .i_pwrite  (pwrite[1]),  .i_paddr   (paddr[1]),
    .i_pwdata  (pwdata[1]),  .o_prdata  (prdata[1]),
    .o_pready  (pready[1]),  .o_pslverr (pslverr[1])
  );

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc_pready%0d", d),  32'(pready[d]),  32'(exp_pready[d]));
        check($sformatf("cyc_pslverr%0d", d), 32'(pslverr[d]), 32'(exp_pslverr[d]));
        check($sformatf("cyc_prdata%0d", d),  prdata[d],       exp_prdata[d]);
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
      exp_prdata[d]  = 32'h0;
      exp_pready[d]  = 1'b0;
      exp_pslverr[d] = 1'b0;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      pwrite[d]  = 1'b0;
      paddr[d]   = 32'h0;
      pwdata[d]  = 32'h0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
      end
    end
  endtask

  // One transfer on DUT d. abort_k >= 0 drops psel in that access cycle; alt
  // changes the address, direction and data during the access phase.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input int abort_k, input bit alt, input logic [31:0] alt_data,
                      output logic [31:0] rdata, output logic slverr,
                      output int ready_k, output int ready_n);
    bit e;
    bit aborted;
    int w;
    e = (addr[1:0] != 2'b00) || (addr >= 32'd64);
    w = (d == 0) ? W0 : W1;
    aborted = 1'b0;
    ready_k = -1; ready_n = 0; rdata = 32'h0; slverr = 1'b0;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      if (k == 0 && !wr) exp_prdata[d] = e ? 32'h0 : mem_m[d][addr[5:2]];
      if (alt) begin
        pwdata[d] = alt_data; paddr[d] = addr ^ 32'h4; pwrite[d] = ~wr;
      end
      if (k == abort_k) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
        aborted = 1'b1;
      end else begin
        penable[d] = 1'b1;
        exp_pready[d]  = (k == w);
        exp_pslverr[d] = e && (k == w);
      end
      #5;
      if (pready[d]) begin
        ready_n++; ready_k = k; rdata = prdata[d]; slverr = pslverr[d];
      end
      if (aborted) break;
    end
    if (!aborted && wr && !e) mem_m[d][addr[5:2]] = data;
    exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        se;
    int          rk;
    int          rn;

    model_reset();
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_prdata%0d", d),  prdata[d],        32'h0);
      check($sformatf("rst_pready%0d", d),  32'(pready[d]),   32'h0);
      check($sformatf("rst_pslverr%0d", d), 32'(pslverr[d]),  32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    started = 1'b1;
    idle(1);

    // Two wait states: ready only in the third access cycle.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t1_wr_ready_k", rk, 2);
    check("t1_wr_ready_n", rn, 1);
    check("t1_wr_slverr", 32'(se), 32'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_ready_k", rk, 2);

    // Zero wait states, back-to-back write then read.
    xfer(1, 1'b1, 32'h00, 32'h11, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t2_wr_ready_k", rk, 0);
    xfer(1, 1'b0, 32'h00, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t2_rd_ready_k", rk, 0);
    check("t2_rd_data", rd, 32'h11);
    idle(1);

    // Error addresses: out of range (two aliases) and misaligned.
    xfer(0, 1'b1, 32'h40, 32'hBAD0BAD0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_oob_ready_n", rn, 1);
    check("t3_oob_slverr", 32'(se), 32'h1);
    xfer(0, 1'b1, 32'h48, 32'hBAD1BAD1, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_oob2_slverr", 32'(se), 32'h1);
    xfer(0, 1'b1, 32'h06, 32'hBAD2BAD2, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_mis_ready_n", rn, 1);
    check("t3_mis_slverr", 32'(se), 32'h1);
    xfer(0, 1'b0, 32'h40, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_rd_oob_data", rd, 32'h0);
    check("t3_rd_oob_slverr", 32'(se), 32'h1);
    xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_rd_w2_data", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h04, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_rd_w1_data", rd, 32'h0);
    xfer(0, 1'b0, 32'h00, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t3_rd_w0_data", rd, 32'h0);

    // Protocol violation: psel dropped in the second access cycle.
    xfer(0, 1'b1, 32'h3C, 32'h5, 1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t4_abort_ready_n", rn, 0);
    idle(1);
    xfer(0, 1'b0, 32'h3C, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t4_rd_data", rd, 32'h0);
    check("t4_rd_ready_n", rn, 1);

    // Reset in the second wait cycle of a write; prdata holds DEADBEEF going in.
    xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t5_pre_rd_data", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h04; pwdata[0] = 32'hA5A5;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("t5_rst_prdata0",  prdata[0],       32'h0);
    check("t5_rst_pready0",  32'(pready[0]),  32'h0);
    check("t5_rst_pslverr0", 32'(pslverr[0]), 32'h0);
    check("t5_rst_prdata1",  prdata[1],       32'h0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    xfer(0, 1'b0, 32'h04, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t5_rd_w1_data", rd, 32'h0);
    check("t5_rd_w1_ready_k", rk, 2);
    xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t5_rd_w2_data", rd, 32'h0);
    xfer(1, 1'b0, 32'h00, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t5_rd_dut1_data", rd, 32'h0);

    // Bus changes during the access phase are ignored.
    xfer(0, 1'b1, 32'h0C, 32'h1, -1, 1'b1, 32'h2, rd, se, rk, rn);
    check("t6_wr_ready_n", rn, 1);
    xfer(0, 1'b0, 32'h0C, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t6_rd_data", rd, 32'h1);
    xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t6_rd_alias_data", rd, 32'h0);
    xfer(1, 1'b1, 32'h3C, 32'hCAFEF00D, -1, 1'b1, 32'h12345678, rd, se, rk, rn);
    xfer(1, 1'b0, 32'h3C, 32'h0, -1, 1'b0, 32'h0, rd, se, rk, rn);
    check("t6_dut1_rd_data", rd, 32'hCAFEF00D);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
